// File: rtl/fp_compare_resolver_if.sv
// Beat-in / verdict-out handshake bundle for the FP compare result resolver.
interface fp_compare_resolver_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_first;
  logic       in_neg;
  logic       out_valid;
  logic       out_ready;
  logic       out_gt;
  logic       out_lt;
  logic       out_eq;
  logic       out_err;

  modport master (
    output in_valid, in_code, in_first, in_neg, out_ready,
    input  in_ready, out_valid, out_gt, out_lt, out_eq, out_err
  );

  modport slave (
    input  in_valid, in_code, in_first, in_neg, out_ready,
    output in_ready, out_valid, out_gt, out_lt, out_eq, out_err
  );
endinterface

// File: rtl/fp_compare_resolver.sv
// Folds serial per-field compare codes (sign, exponent, mantissa...) into one
// registered gt/lt/eq verdict, swapping magnitude order for negative operands.
module fp_compare_resolver #(
  parameter int N_STAGES = 3,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_compare_resolver_if.slave  bus,
  output logic [CNT_W-1:0]      cmp_count,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int CW = $clog2(N_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic            dec, dec_n;
  logic [1:0]      res, res_n;
  logic            neg, neg_n;
  logic            err, err_n;
  logic            rdy_q, rdy_n;
  logic            vld_q, vld_n;
  logic            gt_q, gt_n, lt_q, lt_n, eq_q, eq_n, oerr_q, oerr_n;
  logic [CNT_W-1:0] cmp_n, drop_n;
  logic            accept, sign_beat, drop_inc;

  function automatic logic onehot3(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  assign accept = bus.in_valid && rdy_q;

  // Next-state, datapath and output-register computation
  always_comb begin
    state_n   = state;
    count_n   = count;
    dec_n     = dec;
    res_n     = res;
    neg_n     = neg;
    err_n     = err;
    gt_n      = gt_q;
    lt_n      = lt_q;
    eq_n      = eq_q;
    oerr_n    = oerr_q;
    cmp_n     = cmp_count;
    drop_n    = drop_count;
    sign_beat = 1'b0;
    drop_inc  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_first) sign_beat = 1'b1;
          else              drop_inc  = 1'b1;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (bus.in_first) begin
            // restart: discard the partial sequence, reuse the beat as a sign beat
            drop_inc  = 1'b1;
            sign_beat = 1'b1;
          end else begin
            err_n = err | ~onehot3(bus.in_code);
            if (!dec && bus.in_code != 3'b100) begin
              dec_n = 1'b1;
              res_n = neg ? {bus.in_code[0], bus.in_code[1]} : bus.in_code[1:0];
            end
            count_n = count + CW'(1);
            if (count_n == CW'(N_STAGES)) begin
              state_n = HOLD;
              oerr_n  = err_n;
              gt_n    = !err_n && dec_n && (res_n == 2'b10);
              lt_n    = !err_n && dec_n && (res_n == 2'b01);
              eq_n    = !err_n && !dec_n;
            end
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_n = IDLE;
          count_n = '0;
          dec_n   = 1'b0;
          res_n   = '0;
          err_n   = 1'b0;
          neg_n   = 1'b0;
          gt_n    = 1'b0;
          lt_n    = 1'b0;
          eq_n    = 1'b0;
          oerr_n  = 1'b0;
          cmp_n   = cmp_count + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // sign field is never swapped; it seeds a fresh comparison
    if (sign_beat) begin
      state_n = ACCUM;
      count_n = CW'(1);
      neg_n   = bus.in_neg;
      err_n   = ~onehot3(bus.in_code);
      dec_n   = (bus.in_code != 3'b100);
      res_n   = (bus.in_code != 3'b100) ? bus.in_code[1:0] : 2'b00;
    end

    if (drop_inc && drop_count != '1) drop_n = drop_count + CNT_W'(1);

    rdy_n = (state_n != HOLD);
    vld_n = (state_n == HOLD);
  end

  // State, datapath and registered output updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      dec        <= 1'b0;
      res        <= '0;
      neg        <= 1'b0;
      err        <= 1'b0;
      rdy_q      <= 1'b1;
      vld_q      <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      oerr_q     <= 1'b0;
      cmp_count  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      dec        <= dec_n;
      res        <= res_n;
      neg        <= neg_n;
      err        <= err_n;
      rdy_q      <= rdy_n;
      vld_q      <= vld_n;
      gt_q       <= gt_n;
      lt_q       <= lt_n;
      eq_q       <= eq_n;
      oerr_q     <= oerr_n;
      cmp_count  <= cmp_n;
      drop_count <= drop_n;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_gt    = gt_q;
  assign bus.out_lt    = lt_q;
  assign bus.out_eq    = eq_q;
  assign bus.out_err   = oerr_q;

endmodule

// File: doc/fp_compare_resolver.md
# fp_compare_resolver

Sequential result resolver for the floating-point comparator datapath. It receives the per-field 3-bit comparison codes (sign, then exponent, then mantissa) as a serial beat stream over a valid/ready handshake. It folds them MSB-field-first into one final greater/less/equal verdict, applying magnitude inversion for negative operands. It presents the verdict on a registered valid/ready output port with protocol-error and statistics reporting.

## Interface
- N_STAGES, 3, beats per comparison, including the sign beat; legal range 2..8.
- CNT_W, 16, width of the statistics counters.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_code  input  3  field comparison code, one-hot: 100 = equal, 010 = A greater, 001 = B greater.
- in_first  input  1  marks the sign beat (first beat of a comparison).
- in_neg  input  1  sampled only on the sign beat; 1 = both operands negative.
- out_valid  output  1  verdict valid.
- out_ready  input  1  verdict consumed when out_valid && out_ready.
- out_gt, out_lt, out_eq  output  1 each  A>B, A<B, A==B; at most one set.
- out_err  output  1  the comparison contained a non-one-hot code.
- cmp_count  output  CNT_W  verdicts delivered; wraps.
- drop_count  output  CNT_W  beats or partial sequences discarded; saturates at all-ones.

## Operation
- FSM states:
  - IDLE: waiting for a sign beat.
  - ACCUM: collecting beats 2..N_STAGES.
  - HOLD: verdict pending.
- Beat counter: width clog2(N_STAGES+1).
- Internal registers:
  - dec: verdict latched.
  - res[1:0]: the latched verdict.
  - neg: latched copy of in_neg.
  - err: latched error flag.
- IDLE:
  - Beat with in_first=1: latch neg=in_neg and evaluate the code. A non-equal sign code sets dec=1 and res from the raw code; negation does not apply to the sign field. Go to ACCUM with count=1.
  - Beat with in_first=0: discard it, increment drop_count, stay in IDLE.
- ACCUM:
  - Beat with in_first=0: if dec=0 and code≠100, set dec=1 and res=code[1:0], swapped when neg=1. If dec=1, the beat is consumed and ignored (short-circuit). Increment count.
  - Beat with in_first=1: abandon the partial sequence, increment drop_count, and treat the beat as a new sign beat (count=1).
- Any accepted code that is not one-hot (000, 011, 101, 110, 111) sets err=1 for the current comparison.
- Transition to HOLD: when the N_STAGES-th beat is accepted, load the outputs:
  - err=1: gt=lt=eq=0, out_err=1.
  - else dec=1: res 10 → gt=1, 01 → lt=1.
  - else: eq=1.
- HOLD: out_valid=1 and the outputs stay stable until out_ready. On the handshake, go to IDLE, increment cmp_count, and clear dec, err and neg.
- Zero (±0) and NaN handling is not performed here; upstream presents these as already-resolved codes.

## Timing
- Reset values:
  - state=IDLE, count=0.
  - in_ready=1, out_valid=0.
  - out_gt=out_lt=out_eq=out_err=0.
  - cmp_count=drop_count=0.
  - All internal registers 0.
- in_ready is 1 in IDLE and ACCUM and 0 in HOLD. It is registered from the state and does not depend on in_valid.
- out_valid rises on the clock edge that accepts the last beat, so it is visible the cycle after that beat.
- Latency from the sign beat to out_valid is N_STAGES cycles at full input rate.
- Throughput is one verdict per N_STAGES+1 cycles; there is no input/output overlap.
- When out_ready is held high, the handshake completes in the first HOLD cycle and in_ready returns the next cycle.
- in_valid gaps in ACCUM stall the sequence indefinitely with no timeout.
- Asserting rst_n low mid-sequence or in HOLD immediately forces all reset values. The pending verdict is lost and is not counted in drop_count.
- The drop_count saturation edge holds at all-ones. cmp_count wraps from all-ones to 0.

## Test plan
- Beats (100, neg=0), 010, 001 with out_ready=1: out_gt=1 with out_valid on cycle 3; cmp_count=1.
- Beats (100, neg=1), 010, 100: out_lt=1, showing the swap for negatives.
- Beats (010, neg=1), 001, 001: out_gt=1. The sign decides; later beats are ignored.
- Beats (100, neg=0), 100, 100: out_eq=1. A second run with beats 100, 110, 001 gives out_err=1 with gt=lt=eq=0.
- A stray beat with in_first=0 in IDLE, then two beats interrupted by a new in_first beat: drop_count=2, and the subsequent full sequence resolves correctly.
- out_ready held low for 5 cycles in HOLD: outputs stay stable, in_ready=0, and in_valid beats are not accepted. Asserting rst_n low in HOLD gives out_valid=0 and in_ready=1 immediately, with counters at 0.
